// File: rtl/store_pkg.sv
// Shared types and constants for the store read-modify-write unit.
package store_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int BYTE_HI        = 31;
  localparam int BYTE_LO        = 24;
  localparam int RD_TIMEOUT_DEF = 15;
  localparam int MEM_DWIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int CNT_W          = 8;

endpackage

// File: rtl/store_rmw_unit_if.sv
// Core-side store request and word-only data memory port of the store unit.
interface store_rmw_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DWIDTH = 32
);
  logic                  st_req;
  logic                  sb_w;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [MEM_DWIDTH-1:0] st_data;
  logic                  st_busy;
  logic                  st_done;
  logic                  st_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic [MEM_DWIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_we;
  logic [MEM_DWIDTH-1:0] mem_wdata;

  modport slave (
    input  st_req, sb_w, st_addr, st_data, mem_rdata, mem_rvalid,
    output st_busy, st_done, st_err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output st_req, sb_w, st_addr, st_data, mem_rdata, mem_rvalid,
    input  st_busy, st_done, st_err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/byte_merge.sv
// Replaces the store byte lane [31:24] of a memory word with a new byte.
module byte_merge
  import store_pkg::*;
#(
  parameter int DW = MEM_DWIDTH_DEF
) (
  input  logic [DW-1:0] i_word_in,
  input  logic [7:0]    i_byte_in,
  output logic [DW-1:0] o_word_out
);

  logic [DW-1:0] w_lane_mask;
  logic [DW-1:0] w_lane_data;

  assign w_lane_mask = {{(DW-8){1'b0}}, 8'hFF} << BYTE_LO;
  assign w_lane_data = {{(DW-8){1'b0}}, i_byte_in} << BYTE_LO;
  assign o_word_out  = (i_word_in & ~w_lane_mask) | w_lane_data;

endmodule

// File: rtl/store_rmw_unit.sv
// Store path: SW goes straight to memory, SB does read / merge byte lane / write back.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int mem_dwidth = MEM_DWIDTH_DEF,
  parameter int addr_width = ADDR_WIDTH_DEF,
  parameter int rd_timeout = RD_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  store_rmw_unit_if.slave  io_st
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(rd_timeout - 1);

  state_e                r_state;
  logic [addr_width-1:0] r_addr;
  logic [7:0]            r_byte;
  logic                  r_sb_w;
  logic [mem_dwidth-1:0] r_buf;
  logic [CNT_W-1:0]      r_cnt;

  logic [mem_dwidth-1:0] w_merged;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_err;
  logic                  w_re;
  logic                  w_we;
  logic [addr_width-1:0] w_mem_addr;
  logic [mem_dwidth-1:0] w_mem_wdata;

  byte_merge #(.DW(mem_dwidth)) u_merge (
    .i_word_in  (io_st.mem_rdata),
    .i_byte_in  (r_byte),
    .o_word_out (w_merged)
  );

  // Control FSM with request latches and read-timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_byte  <= 8'h00;
      r_sb_w  <= 1'b0;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_st.st_req) begin
            r_addr  <= io_st.st_addr;
            r_byte  <= io_st.st_data[7:0];
            r_sb_w  <= io_st.sb_w;
            r_buf   <= io_st.st_data;
            r_state <= io_st.sb_w ? ST_RD : ST_WRITE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD: begin
          r_cnt   <= '0;
          r_state <= r_sb_w ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          // valid data on the last allowed cycle still beats the timeout
          if (io_st.mem_rvalid) begin
            r_buf   <= w_merged;
            r_state <= ST_WRITE;
          end else if (r_cnt == TO_LAST) begin
            r_cnt   <= r_cnt + 8'd1;
            r_state <= ST_ERR;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
            r_state <= ST_WAIT;
          end
        end
        ST_WRITE: r_state <= ST_IDLE;
        ST_ERR:   r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode from registered state and registered data only
  always_comb begin
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_re        = 1'b0;
    w_we        = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_RD: begin
        w_re       = 1'b1;
        w_mem_addr = r_addr;
      end
      ST_WRITE: begin
        w_we        = 1'b1;
        w_done      = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_buf;
      end
      ST_ERR: begin
        w_err = 1'b1;
      end
      default: begin
        w_err = 1'b0;
      end
    endcase
  end

  assign w_busy = (r_state != ST_IDLE);

  assign io_st.st_busy   = w_busy;
  assign io_st.st_done   = w_done;
  assign io_st.st_err    = w_err;
  assign io_st.mem_re    = w_re;
  assign io_st.mem_we    = w_we;
  assign io_st.mem_addr  = w_mem_addr;
  assign io_st.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed self-checking bench for store_rmw_unit (default and short-timeout instances).
module tb_store_rmw_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_rmw_unit_if #(.ADDR_WIDTH(32), .MEM_DWIDTH(32)) bus0 ();
  store_rmw_unit_if #(.ADDR_WIDTH(32), .MEM_DWIDTH(32)) bus1 ();

  store_rmw_unit u_dut (
    .clk   (clk),
    .rst   (rst),
    .io_st (bus0)
  );

  store_rmw_unit #(.rd_timeout(3)) u_dut_to (
    .clk   (clk),
    .rst   (rst),
    .io_st (bus1)
  );

  typedef struct {
    logic        sb;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] mem [logic [31:0]];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.st_req = 1'b0; bus0.sb_w = 1'b0; bus0.st_addr = 32'h0; bus0.st_data = 32'h0;
    bus0.mem_rdata = 32'h0; bus0.mem_rvalid = 1'b0;
    bus1.st_req = 1'b0; bus1.sb_w = 1'b0; bus1.st_addr = 32'h0; bus1.st_data = 32'h0;
    bus1.mem_rdata = 32'h0; bus1.mem_rvalid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int we_cyc = -1;
    int re_cnt = 0;
    int rv_at = -1;
    int bad_busy = 0;
    int overlap = 0;
    logic [31:0] wd = 32'h0;
    logic [31:0] wa = 32'h0;
    logic done = 1'b0;
    bus0.st_req = 1'b1; bus0.sb_w = v.sb; bus0.st_addr = v.addr; bus0.st_data = v.data;
    tick();
    bus0.st_req = 1'b0;
    cyc = 1;
    while (cyc <= 40 && we_cyc < 0) begin
      if (bus0.mem_re && bus0.mem_we) overlap++;
      if (!bus0.st_busy) bad_busy++;
      if (bus0.mem_re) begin re_cnt++; rv_at = cyc + v.delay; end
      if (bus0.mem_we) begin
        we_cyc = cyc; wd = bus0.mem_wdata; wa = bus0.mem_addr; done = bus0.st_done;
      end
      bus0.mem_rvalid = (cyc == rv_at);
      bus0.mem_rdata  = (cyc == rv_at) ? v.rdata : 32'hFFFF_FFFF;
      tick();
      cyc++;
    end
    bus0.mem_rvalid = 1'b0;
    if (we_cyc < 0) begin
      errors++; checks++;
      $display("FAIL vec%0d_timeout actual=no_write required=write", idx);
    end else begin
      check($sformatf("vec%0d_latency", idx), we_cyc, v.exp_lat);
      check($sformatf("vec%0d_wdata", idx), wd, v.exp_wdata);
      check($sformatf("vec%0d_waddr", idx), wa, v.addr);
      check($sformatf("vec%0d_done", idx), {31'd0, done}, 32'd1);
      check($sformatf("vec%0d_reads", idx), re_cnt, v.sb ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_busy_gaps", idx), bad_busy, 32'd0);
      check($sformatf("vec%0d_re_we_overlap", idx), overlap, 32'd0);
      check($sformatf("vec%0d_idle_after", idx), {31'd0, bus0.st_busy}, 32'd0);
      mem[wa] = wd;
    end
  endtask

  // Timeout-instance run; rv_cyc is the cycle carrying mem_rvalid (-1: never)
  task automatic run_to(input int rv_cyc, output int err_cnt, output int we_cnt,
                        output int ev_cyc, output logic [31:0] wd);
    err_cnt = 0; we_cnt = 0; ev_cyc = -1; wd = 32'h0;
    bus1.st_req = 1'b1; bus1.sb_w = 1'b1; bus1.st_addr = 32'h80; bus1.st_data = 32'h0000_00EE;
    tick();
    bus1.st_req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (bus1.st_err) begin err_cnt++; ev_cyc = c; end
      if (bus1.mem_we) begin we_cnt++; ev_cyc = c; wd = bus1.mem_wdata; end
      bus1.mem_rvalid = (c == rv_cyc);
      bus1.mem_rdata  = 32'h1122_3344;
      tick();
    end
    bus1.mem_rvalid = 1'b0;
  endtask

  initial begin
    int err_cnt, we_cnt, ev_cyc, bad;
    int wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] wd;
    int pend;

    vecs[0] = '{1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF, 1};
    vecs[1] = '{1'b1, 32'h0000_0044, 32'h0000_00AB, 32'h1122_3344, 1, 32'hAB22_3344, 3};
    vecs[2] = '{1'b1, 32'h0000_0048, 32'hFFFF_FF5A, 32'hCAFE_F00D, 5, 32'h5AFE_F00D, 7};
    vecs[3] = '{1'b1, 32'h0000_004C, 32'h1234_5600, 32'hFFFF_FFFF, 15, 32'h00FF_FFFF, 17};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 1};

    idle_inputs();
    #12;
    check("rst_ctrl", {27'd0, bus0.st_busy, bus0.st_done, bus0.st_err, bus0.mem_re, bus0.mem_we}, 32'd0);
    check("rst_addr", bus0.mem_addr, 32'd0);
    check("rst_wdata", bus0.mem_wdata, 32'd0);
    check("rst_ctrl_to", {27'd0, bus1.st_busy, bus1.st_done, bus1.st_err, bus1.mem_re, bus1.mem_we}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
      tick();
    end
    check("lb_after_sb", {24'd0, mem[32'h44][31:24]}, 32'h0000_00AB);

    // Reset in the middle of an SB read wait
    bus0.st_req = 1'b1; bus0.sb_w = 1'b1; bus0.st_addr = 32'h50; bus0.st_data = 32'h0000_0099;
    tick();
    bus0.st_req = 1'b0;
    tick(); tick();
    check("mid_rst_pre_busy", {31'd0, bus0.st_busy}, 32'd1);
    rst = 1'b1;
    #2;
    check("mid_rst_ctrl", {27'd0, bus0.st_busy, bus0.st_done, bus0.st_err, bus0.mem_re, bus0.mem_we}, 32'd0);
    check("mid_rst_addr", bus0.mem_addr, 32'd0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      bus0.mem_rvalid = 1'b1; bus0.mem_rdata = 32'h5555_5555;
      tick();
      if (bus0.mem_we || bus0.st_busy || bus0.st_done) bad++;
    end
    bus0.mem_rvalid = 1'b0;
    check("mid_rst_no_write", bad, 32'd0);

    // Timeout: no rvalid, rvalid on the last WAIT cycle, rvalid one cycle late
    run_to(-1, err_cnt, we_cnt, ev_cyc, wd);
    check("to_err_pulses", err_cnt, 32'd1);
    check("to_no_write", we_cnt, 32'd0);
    check("to_err_cycle", ev_cyc, 32'd5);
    check("to_idle_after", {31'd0, bus1.st_busy}, 32'd0);
    run_to(4, err_cnt, we_cnt, ev_cyc, wd);
    check("tob_err_pulses", err_cnt, 32'd0);
    check("tob_writes", we_cnt, 32'd1);
    check("tob_write_cycle", ev_cyc, 32'd5);
    check("tob_wdata", wd, 32'hEE22_3344);
    run_to(5, err_cnt, we_cnt, ev_cyc, wd);
    check("tol_err_pulses", err_cnt, 32'd1);
    check("tol_writes", we_cnt, 32'd0);

    // Back-to-back SW then SB to 0x40 with st_req held and spurious rvalid
    bus0.st_req = 1'b1; bus0.sb_w = 1'b0; bus0.st_addr = 32'h40; bus0.st_data = 32'h0102_0304;
    tick();
    pend = -1;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus0.mem_re && bus0.mem_we) bad++;
      if (bus0.mem_we) begin
        wr_cyc.push_back(c); wr_addr.push_back(bus0.mem_addr); wr_data.push_back(bus0.mem_wdata);
        mem[bus0.mem_addr] = bus0.mem_wdata;
      end
      if (c == 1) begin bus0.sb_w = 1'b1; bus0.st_data = 32'h0000_0077; end
      if (c >= 3) bus0.st_req = 1'b0;
      bus0.mem_rvalid = (c <= 2) || (c == pend);
      bus0.mem_rdata  = (c <= 2) ? 32'hBAD0_BAD0 : mem[32'h40];
      if (bus0.mem_re) pend = c + 1;
      tick();
    end
    bus0.mem_rvalid = 1'b0;
    check("b2b_overlap", bad, 32'd0);
    check("b2b_write_count", wr_cyc.size(), 32'd2);
    if (wr_cyc.size() == 2) begin
      check("b2b_w0_cycle", wr_cyc[0], 32'd1);
      check("b2b_w0_data", wr_data[0], 32'h0102_0304);
      check("b2b_w1_cycle", wr_cyc[1], 32'd5);
      check("b2b_w1_addr", wr_addr[1], 32'h40);
      check("b2b_w1_data", wr_data[1], 32'h7702_0304);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
Store-path counterpart to the load data modifier: it accepts SW/SB store requests from the core and issues them to the word-only data memory.
- SW is written directly.
- SB uses read-modify-write: read the word, replace the byte lane [31:24] with the store byte, write the word back.

The byte lane matches the LB extraction lane, so an SB followed by an LB to the same address returns the stored byte. The unit sits between the execute/memory stage and the data memory port.

Parameters:
mem_dwidth, 32, memory data width; the byte lane is fixed at [31:24].
addr_width, 32, memory address width.
rd_timeout, 15, maximum number of WAIT cycles allowed for mem_rvalid before the unit aborts. Range 1..255.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
st_req  input  1  store request, sampled only in IDLE.
sb_w  input  1  1 = SB (byte store), 0 = SW (word store).
st_addr  input  addr_width  store word address.
st_data  input  mem_dwidth  store data; SB uses st_data[7:0].
st_busy  output  1  high in every state except IDLE; the core stalls while it is high.
st_done  output  1  one-cycle pulse, high during the WRITE cycle.
st_err  output  1  one-cycle pulse when the SB read times out.
mem_addr  output  addr_width  memory address, driven with the latched address in RD and WRITE.
mem_re  output  1  memory read strobe.
mem_rdata  input  mem_dwidth  memory read data.
mem_rvalid  input  1  mem_rdata is valid this cycle.
mem_we  output  1  memory write strobe.
mem_wdata  output  mem_dwidth  memory write data.

Behaviour:
- States: IDLE, RD, WAIT, WRITE, ERR. Outputs are Moore-decoded from registered state and registered data. No combinational path from any input to any output.
- Reset (asynchronous):
  - state goes to IDLE; latched addr/data/sb_w and the timeout counter clear to 0.
  - All outputs are 0, including mem_addr and mem_wdata.
  - Reset mid-operation aborts it; no write is issued and no st_done is produced.
- IDLE:
  - If st_req=1, latch st_addr, st_data and sb_w.
  - Next state is WRITE if sb_w=0, RD if sb_w=1. The buffered word is st_data.
  - If st_req=0, stay in IDLE.
- RD: mem_re=1 and mem_addr=latched address for exactly one cycle. Clear the timeout counter. Next state is WAIT.
- WAIT:
  - If mem_rvalid=1: buffer becomes {latched st_data[7:0], mem_rdata[23:0]}; next state is WRITE.
  - Otherwise the counter increments. When the counter reaches rd_timeout with no valid data, next state is ERR.
  - mem_rvalid in the same cycle the counter reaches rd_timeout is accepted; valid data wins over the timeout.
- WRITE: mem_we=1, mem_addr=latched address, mem_wdata=buffer, st_done=1, for one cycle. Next state is IDLE.
- ERR: st_err=1 for one cycle, with no memory write. Next state is IDLE.
- Latency, counting the st_req sample edge as edge 0:
  - SW: WRITE occupies cycle 1, so the write completes 1 cycle after the request.
  - SB with 1-cycle memory: RD in cycle 1, WAIT in cycle 2 with rvalid, WRITE in cycle 3.
- Boundary conditions:
  - st_req while busy is ignored; the core holds the request under st_busy.
  - mem_rvalid outside WAIT is ignored.
  - mem_re and mem_we are never high in the same cycle.
  - Back-to-back requests: the next st_req is accepted in the IDLE cycle after WRITE/ERR, giving a minimum spacing of 2 cycles for SW.
  - SB to the same address twice in succession is correct, because the write completes before the next read.
- st_busy = (state != IDLE).

Decomposition:
- Package store_pkg holds:
  - the state encoding (IDLE=0, RD=1, WAIT=2, WRITE=3, ERR=4, 3-bit);
  - constants BYTE_HI=31 and BYTE_LO=24;
  - the default rd_timeout.
- One combinational sub-module, byte_merge, takes (word_in, byte_in) and produces {byte_in, word_in[23:0]}.
- The FSM, latches and counter live in store_rmw_unit.

Test Plan:
- Reset: assert rst mid-WAIT of an SB -> next cycle all outputs are 0 and state is IDLE; no mem_we appears afterward without a new request.
- SW: st_req=1, sb_w=0, addr=0x40, data=0xDEADBEEF -> in cycle 1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, st_done=1. mem_re stays 0 throughout.
- SB, 1-cycle memory: word at 0x44 = 0x11223344, st_data=0x000000AB.
  - Cycle 1: mem_re=1.
  - Cycle 3: mem_wdata=0xAB223344, st_done=1.
  - A following LB at 0x44 through the load path returns 0x000000AB.
- SB with mem_rvalid delayed 5 cycles -> st_busy stays high and mem_we stays 0 until valid; the merged write occurs in the cycle after rvalid.
- Timeout: rd_timeout=3, mem_rvalid never asserted -> st_err pulses once, no mem_we, and the unit returns to IDLE. Repeat with rvalid on the boundary cycle -> normal WRITE, no error.
- Back-to-back: SW 0x40 then SB 0x40, with st_req held through busy -> exactly one write each, in order. Spurious mem_rvalid during the SW is ignored.
